// File: rtl/vip_rgb_ycbcr_conv.sv
// ---------------------------------------------------------------------------
// vip_rgb_ycbcr_conv
//
// Pipelined RGB -> YCbCr 4:4:4 colour-space converter for the VIP chain.
// Full-range BT.601 or BT.709 coefficients are chosen per frame. The choice
// is latched on the rising edge of per_img_vsync. A pixel that arrives on
// that same cycle already uses the new selection.
//
// Data path (LAT = 3):
//   S1  nine signed products, component x coefficient
//   S2  three sums, plus chroma offset and rounding constant
//   S3  arithmetic shift by COEF_FRAC, clamp to [0, 2^DATA_W-1], and zero
//       the sample when href is low
// vsync and href travel through a shift register of the same depth.
//
// Optional build macro: YCBCR422_OUT_EN
//   When defined, a fourth stage produces 4:2:2 output and LAT = 4.
//   post_img_Cb carries the rounded pair average of Cb on even pixels and
//   of Cr on odd pixels. A trailing unpaired pixel keeps its own Cb.
//   post_img_Cr is driven 0.
//
// Parameters:
//   DATA_W     bits per colour component (8..12)
//   COEF_FRAC  fractional bits of the coefficients (>= 8). The built-in
//              x256 coefficient table is scaled up to this precision.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   mode_sel                    0 = BT.601, 1 = BT.709; sampled at frame start
//   per_img_vsync/href          input frame / pixel valid
//   per_img_red/green/blue      input components
//   post_img_vsync/href         sync outputs, delayed by LAT
//   post_img_Y/Cb/Cr            converted components, 0 while href is low
//   mode_active                 coefficient set in use for the current frame
// ---------------------------------------------------------------------------
module vip_rgb_ycbcr_conv #(
    parameter int DATA_W    = 8,
    parameter int COEF_FRAC = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode_sel,
    input  logic              per_img_vsync,
    input  logic              per_img_href,
    input  logic [DATA_W-1:0] per_img_red,
    input  logic [DATA_W-1:0] per_img_green,
    input  logic [DATA_W-1:0] per_img_blue,
    output logic              post_img_vsync,
    output logic              post_img_href,
    output logic [DATA_W-1:0] post_img_Y,
    output logic [DATA_W-1:0] post_img_Cb,
    output logic [DATA_W-1:0] post_img_Cr,
    output logic              mode_active
);

`ifdef YCBCR422_OUT_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif
    localparam int SW = DATA_W + COEF_FRAC + 3;
    localparam logic signed [SW-1:0] ROUND_C = SW'(2 ** (COEF_FRAC - 1));
    localparam logic signed [SW-1:0] OFFS_C  = SW'(2 ** (DATA_W - 1 + COEF_FRAC));
    localparam logic signed [SW-1:0] MAX_C   = SW'(2 ** DATA_W - 1);

    // Coefficient table, row-major: idx 0..2 = Y(R,G,B), 3..5 = Cb, 6..8 = Cr.
    function automatic logic signed [SW-1:0] coef(input logic bt709, input int idx);
        int c;
        case (idx)
            0:       c = bt709 ?   54 :   77;
            1:       c = bt709 ?  183 :  150;
            2:       c = bt709 ?   19 :   29;
            3:       c = bt709 ?  -29 :  -43;
            4:       c = bt709 ?  -99 :  -85;
            5:       c = 128;
            6:       c = 128;
            7:       c = bt709 ? -116 : -107;
            default: c = bt709 ?  -12 :  -21;
        endcase
        return SW'(c * (2 ** (COEF_FRAC - 8)));
    endfunction

    // ---------------- frame-start mode latch ----------------
    logic vsync_prev_q;
    logic mode_q;
    logic mode_d;
    logic frame_rise;

    // After reset vsync_prev_q is 0, so a vsync that is already high
    // counts as a new frame start.
    assign frame_rise  = per_img_vsync & ~vsync_prev_q;
    // mode_d feeds S1 directly, so the pixel on the rise cycle sees the new mode.
    assign mode_d      = frame_rise ? mode_sel : mode_q;
    assign mode_active = mode_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_prev_q <= 1'b0;
            mode_q       <= 1'b0;
        end else begin
            vsync_prev_q <= per_img_vsync;
            mode_q       <= mode_d;
        end
    end

    // ---------------- sync delay line ----------------
    logic [LAT-1:0] vs_q;
    logic [LAT-1:0] hs_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vs_q <= '0;
            hs_q <= '0;
        end else begin
            vs_q <= {vs_q[LAT-2:0], per_img_vsync};
            hs_q <= {hs_q[LAT-2:0], per_img_href};
        end
    end

    assign post_img_vsync = vs_q[LAT-1];
    assign post_img_href  = hs_q[LAT-1];

    // ---------------- S1: products ----------------
    logic        [DATA_W-1:0] comp   [3];
    logic signed [SW-1:0]     prod_d [9];
    logic signed [SW-1:0]     prod_q [9];

    assign comp[0] = per_img_red;
    assign comp[1] = per_img_green;
    assign comp[2] = per_img_blue;

    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_prod
            assign prod_d[gi] = $signed({{(SW-DATA_W){1'b0}}, comp[gi % 3]}) * coef(mode_d, gi);
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < 9; i++) begin
            if (rst) prod_q[i] <= '0;
            else     prod_q[i] <= prod_d[i];
        end
    end

    // ---------------- S2: sums, S3: shift + clamp ----------------
    logic signed [SW-1:0]     sum_d [3];
    logic signed [SW-1:0]     sum_q [3];
    logic signed [SW-1:0]     shr   [3];
    logic        [DATA_W-1:0] res_d [3];
    logic        [DATA_W-1:0] res_q [3];

    generate
        for (gi = 0; gi < 3; gi++) begin : g_sum
            // Chroma is centred at 2^(DATA_W-1). All three channels round half up.
            assign sum_d[gi] = prod_q[3*gi] + prod_q[3*gi+1] + prod_q[3*gi+2]
                             + ((gi == 0) ? ROUND_C : (OFFS_C + ROUND_C));
            assign shr[gi]   = sum_q[gi] >>> COEF_FRAC;
            // hs_q[1] is the href of the pixel now in S2, so a blank slot
            // leaves S3 as zero.
            assign res_d[gi] = !hs_q[1]           ? '0 :
                               (shr[gi] < 0)      ? '0 :
                               (shr[gi] > MAX_C)  ? MAX_C[DATA_W-1:0] :
                                                    shr[gi][DATA_W-1:0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                sum_q[i] <= '0;
                res_q[i] <= '0;
            end else begin
                sum_q[i] <= sum_d[i];
                res_q[i] <= res_d[i];
            end
        end
    end

`ifdef YCBCR422_OUT_EN
    // ---------------- S4: 4:2:2 chroma pairing ----------------
    // par_q is the parity of the pixel in S3 within the current href run.
    // An even pixel is paired with the next pixel, which is still in S2.
    // Its clamped value is already available combinationally as res_d.
    logic [DATA_W-1:0] y4_q;
    logic [DATA_W-1:0] c4_q;
    logic [DATA_W-1:0] c4_d;
    logic [DATA_W-1:0] cr_hold_q;
    logic [DATA_W-1:0] avg_cb;
    logic [DATA_W-1:0] avg_cr;
    logic              par_q;

    assign avg_cb = DATA_W'(({1'b0, res_q[1]} + {1'b0, res_d[1]} + (DATA_W+1)'(1)) >> 1);
    assign avg_cr = DATA_W'(({1'b0, cr_hold_q} + {1'b0, res_q[2]} + (DATA_W+1)'(1)) >> 1);

    always_comb begin
        c4_d = '0;
        if (hs_q[2]) begin
            if (!par_q) c4_d = hs_q[1] ? avg_cb : res_q[1];
            else        c4_d = avg_cr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y4_q      <= '0;
            c4_q      <= '0;
            cr_hold_q <= '0;
            par_q     <= 1'b0;
        end else begin
            y4_q  <= res_q[0];
            c4_q  <= c4_d;
            par_q <= hs_q[2] ? ~par_q : 1'b0;
            if (hs_q[2] && !par_q) cr_hold_q <= res_q[2];
        end
    end

    assign post_img_Y  = y4_q;
    assign post_img_Cb = c4_q;
    assign post_img_Cr = '0;
`else
    assign post_img_Y  = res_q[0];
    assign post_img_Cb = res_q[1];
    assign post_img_Cr = res_q[2];
`endif

endmodule

// File: tb/tb_vip_rgb_ycbcr_conv.sv
// ---------------------------------------------------------------------------
// Testbench for vip_rgb_ycbcr_conv (DATA_W = 8, COEF_FRAC = 8).
// Inputs change on the falling edge. Every falling edge records the DUT
// outputs into a log indexed by cycle number. The output produced by an
// input driven in cycle c is read back from log entry c + LAT.
// ---------------------------------------------------------------------------
module tb_vip_rgb_ycbcr_conv;

`ifdef YCBCR422_OUT_EN
    localparam int LAT  = 4;
    localparam bit C422 = 1'b1;
`else
    localparam int LAT  = 3;
    localparam bit C422 = 1'b0;
`endif
    localparam int LOGN = 4096;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mode_sel = 1'b0;
    logic       vs = 1'b0;
    logic       hs = 1'b0;
    logic [7:0] r = 8'd0, g = 8'd0, b = 8'd0;
    logic       post_vs, post_hs, ma;
    logic [7:0] py, pcb, pcr;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic       lvs [LOGN];
    logic       lhs [LOGN];
    logic       lma [LOGN];
    logic [7:0] ly  [LOGN];
    logic [7:0] lcb [LOGN];
    logic [7:0] lcr [LOGN];

    // per-frame stimulus record for the random frame test
    logic       f_h [1024];
    logic [7:0] f_r [1024];
    logic [7:0] f_g [1024];
    logic [7:0] f_b [1024];
    int         f_n;
    int         f_s;

    vip_rgb_ycbcr_conv #(.DATA_W(8), .COEF_FRAC(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .mode_sel       (mode_sel),
        .per_img_vsync  (vs),
        .per_img_href   (hs),
        .per_img_red    (r),
        .per_img_green  (g),
        .per_img_blue   (b),
        .post_img_vsync (post_vs),
        .post_img_href  (post_hs),
        .post_img_Y     (py),
        .post_img_Cb    (pcb),
        .post_img_Cr    (pcr),
        .mode_active    (ma)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        lvs[cyc % LOGN] = post_vs;
        lhs[cyc % LOGN] = post_hs;
        lma[cyc % LOGN] = ma;
        ly [cyc % LOGN] = py;
        lcb[cyc % LOGN] = pcb;
        lcr[cyc % LOGN] = pcr;
    end

    function automatic int li(input int s);
        return s % LOGN;
    endfunction

    function automatic int clamp255(input int v);
        return (v < 0) ? 0 : ((v > 255) ? 255 : v);
    endfunction

    // Golden model: sel 0 = Y, 1 = Cb, 2 = Cr, straight from the x256 equations.
    function automatic int ycc(input int sel, input int rr, input int gg, input int bb, input bit m);
        int v;
        case (sel)
            0:       v =  (m ? 54 : 77) * rr + (m ? 183 : 150) * gg + (m ? 19 : 29) * bb + 128;
            1:       v = -(m ? 29 : 43) * rr - (m ? 99 : 85) * gg + 128 * bb + 32768 + 128;
            default: v = 128 * rr - (m ? 116 : 107) * gg - (m ? 12 : 21) * bb + 32768 + 128;
        endcase
        return clamp255(v >>> 8);
    endfunction

    task automatic drive(input logic rs, input logic v, input logic h,
                         input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb,
                         output int st);
        @(negedge clk);
        rst = rs; vs = v; hs = h; r = rr; g = gg; b = bb;
        st = cyc;
    endtask

    task automatic idle_n(input int n, input logic v);
        int st;
        repeat (n) drive(1'b0, v, 1'b0, 8'd0, 8'd0, 8'd0, st);
    endtask

    task automatic frame_drive(input logic h, input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb);
        int st;
        drive(1'b0, 1'b1, h, rr, gg, bb, st);
        if (f_n == 0) f_s = st;
        f_h[f_n] = h; f_r[f_n] = rr; f_g[f_n] = gg; f_b[f_n] = bb;
        f_n++;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        int sa, sb, sc, i;
        rst = 1'b1;
        mode_sel = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 8'd255, 8'd255, 8'd255, sa);
        drive(1'b1, 1'b1, 1'b1, 8'd255, 8'd255, 8'd255, sb);
        drive(1'b1, 1'b1, 1'b1, 8'd255, 8'd255, 8'd255, sc);
        mode_sel = 1'b0;
        idle_n(LAT + 2, 1'b0);
        i = li(sa + 1);
        total++;
        if ({lvs[i], lhs[i], lma[i], ly[i], lcb[i], lcr[i]} !== 27'd0) begin
            bad++;
            $display("FAIL reset_early: got vs/hs/ma/Y/Cb/Cr=%0b/%0b/%0b/%0d/%0d/%0d want all 0",
                     lvs[i], lhs[i], lma[i], ly[i], lcb[i], lcr[i]);
        end
        i = li(sc + 1);
        total++;
        if ({lvs[i], lhs[i], lma[i], ly[i], lcb[i], lcr[i]} !== 27'd0) begin
            bad++;
            $display("FAIL reset_held: got vs/hs/ma/Y/Cb/Cr=%0b/%0b/%0b/%0d/%0d/%0d want all 0",
                     lvs[i], lhs[i], lma[i], ly[i], lcb[i], lcr[i]);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_white_black();
        int s0, s1, st, i;
        logic [7:0] cr_w;
        cr_w = C422 ? 8'd0 : 8'd128;
        mode_sel = 1'b0;
        idle_n(2, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0, st);
        drive(1'b0, 1'b1, 1'b1, 8'd255, 8'd255, 8'd255, s0);
        drive(1'b0, 1'b1, 1'b1, 8'd0, 8'd0, 8'd0, s1);
        idle_n(3, 1'b1);
        idle_n(LAT + 2, 1'b0);

        i = li(s0 + LAT - 1);
        total++;
        if (lhs[i] !== 1'b0) begin
            bad++;
            $display("FAIL wb_href_early: got href=%0b want 0", lhs[i]);
        end
        i = li(s0 + LAT);
        total++;
        if ({lvs[i], lhs[i], ly[i], lcb[i], lcr[i]} !== {1'b1, 1'b1, 8'd255, 8'd128, cr_w}) begin
            bad++;
            $display("FAIL wb_white: got vs/hs/Y/Cb/Cr=%0b/%0b/%0d/%0d/%0d want 1/1/255/128/%0d",
                     lvs[i], lhs[i], ly[i], lcb[i], lcr[i], cr_w);
        end
        i = li(s1 + LAT);
        total++;
        if ({lhs[i], ly[i], lcb[i], lcr[i]} !== {1'b1, 8'd0, 8'd128, cr_w}) begin
            bad++;
            $display("FAIL wb_black: got hs/Y/Cb/Cr=%0b/%0d/%0d/%0d want 1/0/128/%0d",
                     lhs[i], ly[i], lcb[i], lcr[i], cr_w);
        end
        i = li(s1 + LAT + 1);
        total++;
        if ({lhs[i], ly[i], lcb[i], lcr[i]} !== 25'd0) begin
            bad++;
            $display("FAIL wb_blank_zero: got hs/Y/Cb/Cr=%0b/%0d/%0d/%0d want 0/0/0/0",
                     lhs[i], ly[i], lcb[i], lcr[i]);
        end
    endtask

    // ------------------------------------------------------------------
    // red, blue, white in one line: clamp of Cr; in 4:2:2 also a pair and
    // a trailing unpaired pixel.
    task automatic test_clamp_and_pairs();
        int s0, s1, s2, st, i;
        logic [7:0] e_cb [3];
        logic [7:0] e_cr [3];
        logic [7:0] e_y  [3];
        int         sv   [3];
        e_y[0] = 8'd77;  e_cb[0] = C422 ? 8'd170 : 8'd85;  e_cr[0] = C422 ? 8'd0 : 8'd255;
        e_y[1] = 8'd29;  e_cb[1] = C422 ? 8'd181 : 8'd255; e_cr[1] = C422 ? 8'd0 : 8'd107;
        e_y[2] = 8'd255; e_cb[2] = 8'd128;                 e_cr[2] = C422 ? 8'd0 : 8'd128;
        mode_sel = 1'b0;
        idle_n(2, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0, st);
        drive(1'b0, 1'b1, 1'b1, 8'd255, 8'd0, 8'd0, s0);
        drive(1'b0, 1'b1, 1'b1, 8'd0, 8'd0, 8'd255, s1);
        drive(1'b0, 1'b1, 1'b1, 8'd255, 8'd255, 8'd255, s2);
        idle_n(2, 1'b1);
        idle_n(LAT + 2, 1'b0);
        sv[0] = s0; sv[1] = s1; sv[2] = s2;
        for (int k = 0; k < 3; k++) begin
            i = li(sv[k] + LAT);
            total++;
            if ({lhs[i], ly[i], lcb[i], lcr[i]} !== {1'b1, e_y[k], e_cb[k], e_cr[k]}) begin
                bad++;
                $display("FAIL clamp_px%0d: got hs/Y/Cb/Cr=%0b/%0d/%0d/%0d want 1/%0d/%0d/%0d",
                         k, lhs[i], ly[i], lcb[i], lcr[i], e_y[k], e_cb[k], e_cr[k]);
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_mode_latch();
        int sr, sa, sb, sc, st, i;
        logic [7:0] cr_r;
        cr_r = C422 ? 8'd0 : 8'd255;
        mode_sel = 1'b1;
        idle_n(2, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0, sr);
        drive(1'b0, 1'b1, 1'b1, 8'd255, 8'd0, 8'd0, sa);
        mode_sel = 1'b0;
        drive(1'b0, 1'b1, 1'b1, 8'd255, 8'd0, 8'd0, sb);
        idle_n(2, 1'b1);
        idle_n(2, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 8'd255, 8'd0, 8'd0, sc);
        idle_n(2, 1'b1);
        idle_n(LAT + 2, 1'b0);

        total++;
        if (lma[li(sr + 1)] !== 1'b1) begin
            bad++;
            $display("FAIL mode_latched: got mode_active=%0b want 1", lma[li(sr + 1)]);
        end
        total++;
        if (lma[li(sb + 1)] !== 1'b1) begin
            bad++;
            $display("FAIL mode_midframe_hold: got mode_active=%0b want 1", lma[li(sb + 1)]);
        end
        i = li(sa + LAT);
        total++;
        if ({lhs[i], ly[i], lcb[i], lcr[i]} !== {1'b1, 8'd54, 8'd99, cr_r}) begin
            bad++;
            $display("FAIL mode709_red: got hs/Y/Cb/Cr=%0b/%0d/%0d/%0d want 1/54/99/%0d",
                     lhs[i], ly[i], lcb[i], lcr[i], cr_r);
        end
        i = li(sb + LAT);
        total++;
        if ({lhs[i], ly[i], lcb[i], lcr[i]} !== {1'b1, 8'd54, (C422 ? 8'd255 : 8'd99), cr_r}) begin
            bad++;
            $display("FAIL mode709_toggle_ignored: got hs/Y/Cb/Cr=%0b/%0d/%0d/%0d want 1/54/%0d/%0d",
                     lhs[i], ly[i], lcb[i], lcr[i], (C422 ? 8'd255 : 8'd99), cr_r);
        end
        total++;
        if (lma[li(sc + 1)] !== 1'b0) begin
            bad++;
            $display("FAIL mode_next_frame: got mode_active=%0b want 0", lma[li(sc + 1)]);
        end
        i = li(sc + LAT);
        total++;
        if ({lhs[i], ly[i], lcb[i], lcr[i]} !== {1'b1, 8'd77, 8'd85, cr_r}) begin
            bad++;
            $display("FAIL mode601_rise_px: got hs/Y/Cb/Cr=%0b/%0d/%0d/%0d want 1/77/85/%0d",
                     lhs[i], ly[i], lcb[i], lcr[i], cr_r);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_midline();
        int sr, s0, s1, sx, sy, sz, st, i;
        mode_sel = 1'b0;
        idle_n(2, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0, sr);
        drive(1'b0, 1'b1, 1'b1, 8'd255, 8'd255, 8'd255, s0);
        drive(1'b0, 1'b1, 1'b1, 8'd255, 8'd255, 8'd255, s1);
        drive(1'b1, 1'b1, 1'b1, 8'd255, 8'd255, 8'd255, sx);
        drive(1'b1, 1'b1, 1'b1, 8'd255, 8'd255, 8'd255, sy);
        mode_sel = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 8'd255, 8'd0, 8'd0, sz);
        drive(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0, st);
        idle_n(1, 1'b1);
        idle_n(LAT + 2, 1'b0);
        mode_sel = 1'b0;

        i = li(sx + 1);
        total++;
        if ({lvs[i], lhs[i], lma[i], ly[i], lcb[i], lcr[i]} !== 27'd0) begin
            bad++;
            $display("FAIL rstmid_flush: got vs/hs/ma/Y/Cb/Cr=%0b/%0b/%0b/%0d/%0d/%0d want all 0",
                     lvs[i], lhs[i], lma[i], ly[i], lcb[i], lcr[i]);
        end
        i = li(sy + 1);
        total++;
        if ({lvs[i], lhs[i], ly[i], lcb[i], lcr[i]} !== 26'd0) begin
            bad++;
            $display("FAIL rstmid_hold: got vs/hs/Y/Cb/Cr=%0b/%0b/%0d/%0d/%0d want all 0",
                     lvs[i], lhs[i], ly[i], lcb[i], lcr[i]);
        end
        total++;
        if (lma[li(sz + 1)] !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_rise: got mode_active=%0b want 1", lma[li(sz + 1)]);
        end
        i = li(sz + LAT - 1);
        total++;
        if ({lvs[i], lhs[i]} !== 2'b00) begin
            bad++;
            $display("FAIL rstmid_no_stale: got vs/hs=%0b/%0b want 0/0", lvs[i], lhs[i]);
        end
        i = li(sz + LAT);
        total++;
        if ({lvs[i], lhs[i], ly[i], lcb[i], lcr[i]} !== {1'b1, 1'b1, 8'd54, 8'd99, (C422 ? 8'd0 : 8'd255)}) begin
            bad++;
            $display("FAIL rstmid_first_px: got vs/hs/Y/Cb/Cr=%0b/%0b/%0d/%0d/%0d want 1/1/54/99/%0d",
                     lvs[i], lhs[i], ly[i], lcb[i], lcr[i], (C422 ? 8'd0 : 8'd255));
        end
    endtask

    // ------------------------------------------------------------------
    // Random 24x8 frame with blanking and random href gaps; mode_sel is
    // scrambled after the frame start and must have no effect.
    task automatic test_frame(input bit m);
        int ey [1024];
        int ecb[1024];
        int ecr[1024];
        int oc, i, par, errs;
        logic [7:0] xy, xcb, xcr;
        mode_sel = m;
        idle_n(3, 1'b0);
        f_n = 0;
        for (int ln = 0; ln < 8; ln++) begin
            for (int j = 0; j < 4; j++) frame_drive(1'b0, 8'd0, 8'd0, 8'd0);
            for (int p = 0; p < 24; p++) begin
                if ($urandom_range(0, 5) == 0) frame_drive(1'b0, 8'd0, 8'd0, 8'd0);
                frame_drive(1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                            8'($urandom_range(0, 255)));
                mode_sel = 1'($urandom_range(0, 1));
            end
        end
        for (int j = 0; j < 3; j++) frame_drive(1'b0, 8'd0, 8'd0, 8'd0);
        idle_n(LAT + 3, 1'b0);
        mode_sel = 1'b0;

        for (int k = 0; k < f_n; k++) begin
            ey[k]  = f_h[k] ? ycc(0, int'(f_r[k]), int'(f_g[k]), int'(f_b[k]), m) : 0;
            ecb[k] = f_h[k] ? ycc(1, int'(f_r[k]), int'(f_g[k]), int'(f_b[k]), m) : 0;
            ecr[k] = f_h[k] ? ycc(2, int'(f_r[k]), int'(f_g[k]), int'(f_b[k]), m) : 0;
        end

        total++;
        if (lma[li(f_s + 1)] !== m) begin
            bad++;
            $display("FAIL frame%0d_mode: got mode_active=%0b want %0b", m, lma[li(f_s + 1)], m);
        end
        total++;
        if ({lvs[li(f_s + LAT - 1)], lvs[li(f_s + f_n + LAT)]} !== 2'b00) begin
            bad++;
            $display("FAIL frame%0d_vsync_bounds: got before/after=%0b/%0b want 0/0",
                     m, lvs[li(f_s + LAT - 1)], lvs[li(f_s + f_n + LAT)]);
        end

        par  = 0;
        errs = 0;
        for (int k = 0; k < f_n; k++) begin
            if (!f_h[k]) begin
                par = 0;
                oc  = 0;
            end else if (par == 0) begin
                oc  = (k + 1 < f_n && f_h[k+1]) ? (ecb[k] + ecb[k+1] + 1) / 2 : ecb[k];
                par = 1;
            end else begin
                oc  = (ecr[k-1] + ecr[k] + 1) / 2;
                par = 0;
            end
            xy  = 8'(ey[k]);
            xcb = C422 ? 8'(oc) : 8'(ecb[k]);
            xcr = C422 ? 8'd0   : 8'(ecr[k]);
            i = li(f_s + k + LAT);
            total++;
            if ({lvs[i], lhs[i], ly[i], lcb[i], lcr[i]} !== {1'b1, f_h[k], xy, xcb, xcr}) begin
                bad++;
                errs++;
                if (errs <= 8)
                    $display("FAIL frame%0d_px%0d: got vs/hs/Y/Cb/Cr=%0b/%0b/%0d/%0d/%0d want 1/%0b/%0d/%0d/%0d",
                             m, k, lvs[i], lhs[i], ly[i], lcb[i], lcr[i], f_h[k], xy, xcb, xcr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_white_black();
        test_clamp_and_pairs();
        test_mode_latch();
        test_reset_midline();
        test_frame(1'b0);
        test_frame(1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
